// File: rtl/mem_1rw_arbiter.sv
// mem_1rw_arbiter
//   Shares one external single-port RAM between a write requester and a read
//   requester. At most one RAM access per cycle; round-robin on contention.
//   Read data returns in order through a show-ahead response FIFO. A credit
//   counter limits reads in flight so every issued read has a FIFO slot.
// Ports
//   clk, rst_n                       clock, async active-low reset
//   wr_req_valid/ready/addr/data     write request handshake
//   rd_req_valid/ready/addr          read request handshake
//   rd_rsp_valid/ready/data          read response (FIFO head)
//   mem_wen/ren/addr/din, mem_dout   RAM interface (LAT = 1, or 2 with DOUT_REG)
module mem_1rw_arbiter #(
  parameter int unsigned WIDTH_DATA     = 8,
  parameter int unsigned WIDTH_ADDR     = 8,
  parameter string       DOUT_REG       = "false",
  parameter int unsigned RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [WIDTH_ADDR-1:0] wr_req_addr,
  input  logic [WIDTH_DATA-1:0] wr_req_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [WIDTH_ADDR-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [WIDTH_DATA-1:0] rd_rsp_data,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [WIDTH_DATA-1:0] mem_din,
  input  logic [WIDTH_DATA-1:0] mem_dout
);

  localparam int unsigned LAT   = (DOUT_REG == "true") ? 2 : 1;
  localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_FIFO_DEPTH);

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic [LAT-1:0]        rd_pipe_q, rd_pipe_d;
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [WIDTH_DATA-1:0] fifo_mem_q [RSP_FIFO_DEPTH];
  logic [WIDTH_DATA-1:0] fifo_mem_d [RSP_FIFO_DEPTH];

  logic rd_elig;
  logic grant_w;
  logic grant_r;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  // Arbitration and RAM drive. Grants are gated by rst_n so nothing is
  // accepted or issued while reset is asserted.
  always_comb begin
    rd_elig = rd_req_valid && (outst_q < DEPTH_CNT);
    grant_w = 1'b0;
    grant_r = 1'b0;
    prio_d  = prio_q;
    if (rst_n) begin
      if (wr_req_valid && rd_elig) begin
        if (prio_q == PRIO_WR) begin
          grant_w = 1'b1;
          prio_d  = PRIO_RD;
        end else begin
          grant_r = 1'b1;
          prio_d  = PRIO_WR;
        end
      end else if (wr_req_valid) begin
        grant_w = 1'b1;
      end else if (rd_elig) begin
        grant_r = 1'b1;
      end
    end
  end

  assign wr_req_ready = grant_w;
  assign rd_req_ready = grant_r;
  assign mem_wen      = grant_w;
  assign mem_ren      = grant_r;
  assign mem_addr     = grant_r ? rd_req_addr : wr_req_addr;
  assign mem_din      = wr_req_data;

  // Response FIFO status; extra pointer MSB separates full from empty.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_rsp_valid = !fifo_empty;
  assign rd_rsp_data  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Read pipe, FIFO pointers and credit counter. A pop only releases its
  // credit from the next cycle on, keeping rd_rsp_ready off the
  // rd_req_ready path.
  always_comb begin
    push      = rd_pipe_q[LAT-1];
    pop       = rd_rsp_valid && rd_rsp_ready;
    rd_pipe_d = (rd_pipe_q << 1) | LAT'(grant_r);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    outst_d   = outst_q;
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = mem_dout;
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
    if (grant_r && !pop) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!grant_r && pop) begin
      outst_d = outst_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= PRIO_WR;
      rd_pipe_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      outst_q   <= '0;
    end else begin
      prio_q    <= prio_d;
      rd_pipe_q <= rd_pipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      outst_q   <= outst_d;
    end
  end

  // FIFO storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) outst_q <= DEPTH_CNT);
  a_one_access:   assert property (@(posedge clk) disable iff (!rst_n) !(mem_wen && mem_ren));

endmodule
